// File: rtl/strobe_timer_bank.sv
// rtl/strobe_timer_bank.sv - bank of independent programmable strobe counters
//
// Each channel counts qualified ticks and emits a one-cycle strobe every
// cur_period ticks, periodic or one-shot. Period/mode writes land in shadow
// registers and are copied into the working registers only on arm or at a
// period boundary, so a write never shortens or skips an interval.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   tick_en      per-channel count qualifier
//   arm          per-channel start/restart pulse
//   disarm       per-channel stop pulse
//   cfg_we       configuration write strobe
//   cfg_ch       target channel (values >= CHANNELS are ignored)
//   cfg_period   new period in ticks
//   cfg_oneshot  new mode: 1 = one-shot, 0 = periodic
//   strobe       registered one-cycle strobe per channel
//   active       channel armed and counting
module strobe_timer_bank #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] tick_en,
   input  logic [CHANNELS-1:0] arm,
   input  logic [CHANNELS-1:0] disarm,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_period,
   input  logic                cfg_oneshot,
   output logic [CHANNELS-1:0] strobe,
   output logic [CHANNELS-1:0] active
);

   logic [WIDTH-1:0]    shadow_period [CHANNELS];
   logic [CHANNELS-1:0] shadow_oneshot;
   logic [WIDTH-1:0]    cur_period    [CHANNELS];
   logic [CHANNELS-1:0] cur_oneshot;
   logic [WIDTH-1:0]    count         [CHANNELS];
   logic [CHANNELS-1:0] run;

   // Shadow contents as they will be after this cycle's write, so an arm or
   // boundary reload in the same cycle as a write picks up the new values.
   // An out-of-range cfg_ch matches no channel and is dropped.
   logic [CHANNELS-1:0] wr_hit;
   logic [WIDTH-1:0]    next_period  [CHANNELS];
   logic [CHANNELS-1:0] next_oneshot;

   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         wr_hit[n]       = cfg_we && (cfg_ch == CH_W'(n));
         next_period[n]  = wr_hit[n] ? cfg_period  : shadow_period[n];
         next_oneshot[n] = wr_hit[n] ? cfg_oneshot : shadow_oneshot[n];
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < CHANNELS; n++) begin
         if (rst) begin
            shadow_period[n]  <= '0;
            shadow_oneshot[n] <= 1'b0;
            cur_period[n]     <= '0;
            cur_oneshot[n]    <= 1'b0;
            count[n]          <= WIDTH'(1);
            run[n]            <= 1'b0;
            strobe[n]         <= 1'b0;
         end else begin
            shadow_period[n]  <= next_period[n];
            shadow_oneshot[n] <= next_oneshot[n];
            strobe[n]         <= 1'b0;
            if (arm[n]) begin
               count[n]       <= WIDTH'(1);
               run[n]         <= 1'b1;
               cur_period[n]  <= next_period[n];
               cur_oneshot[n] <= next_oneshot[n];
            end else if (disarm[n]) begin
               count[n] <= WIDTH'(1);
               run[n]   <= 1'b0;
            end else if (run[n] && tick_en[n]) begin
               if (cur_period[n] == '0) begin
                  // Period 0 parks the counter at 1; stays armed, never fires.
                  count[n] <= WIDTH'(1);
               end else if (count[n] == cur_period[n]) begin
                  strobe[n]      <= 1'b1;
                  count[n]       <= WIDTH'(1);
                  cur_period[n]  <= next_period[n];
                  cur_oneshot[n] <= next_oneshot[n];
                  // The mode of the interval just finished decides the stop.
                  if (cur_oneshot[n]) run[n] <= 1'b0;
               end else begin
                  count[n] <= count[n] + WIDTH'(1);
               end
            end
         end
      end
   end

   assign active = run;

endmodule

// File: tb/tb_strobe_timer_bank.sv
// tb/tb_strobe_timer_bank.sv - self-checking bench for strobe_timer_bank
module tb_strobe_timer_bank;

   localparam int WIDTH = 16;
   localparam int NCH   = 5;
   localparam int CHW   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   tick_en, arm, disarm;
   logic             cfg_we;
   logic [CHW-1:0]   cfg_ch;
   logic [WIDTH-1:0] cfg_period;
   logic             cfg_oneshot;
   logic [NCH-1:0]   strobe, active;

   strobe_timer_bank #(.WIDTH(WIDTH), .CHANNELS(NCH)) dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .arm(arm), .disarm(disarm),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_oneshot(cfg_oneshot), .strobe(strobe), .active(active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: per channel, the programmed period/mode, the period in force,
   // and how many qualified ticks have elapsed in the current interval.
   int       sh_p [NCH];
   bit       sh_o [NCH];
   int       cp   [NCH];
   bit       co   [NCH];
   int       elapsed [NCH];
   bit       running [NCH];
   bit       fired   [NCH];
   int       scnt    [NCH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int n = 0; n < NCH; n++) begin
         if (rst) begin
            sh_p[n] = 0; sh_o[n] = 0; cp[n] = 0; co[n] = 0;
            elapsed[n] = 0; running[n] = 0; fired[n] = 0;
         end else begin
            if (cfg_we && int'(cfg_ch) == n) begin
               sh_p[n] = int'(cfg_period);
               sh_o[n] = cfg_oneshot;
            end
            fired[n] = 0;
            if (arm[n]) begin
               running[n] = 1; elapsed[n] = 0; cp[n] = sh_p[n]; co[n] = sh_o[n];
            end else if (disarm[n]) begin
               running[n] = 0; elapsed[n] = 0;
            end else if (running[n] && tick_en[n] && cp[n] != 0) begin
               elapsed[n] = elapsed[n] + 1;
               if (elapsed[n] == cp[n]) begin
                  fired[n] = 1;
                  elapsed[n] = 0;
                  if (co[n]) running[n] = 0;
                  cp[n] = sh_p[n]; co[n] = sh_o[n];
               end
            end
         end
      end
   endtask

   task automatic cycle();
      logic [NCH-1:0] es, ea;
      @(posedge clk);
      model_step();
      #1;
      for (int n = 0; n < NCH; n++) begin
         es[n] = fired[n];
         ea[n] = running[n];
         if (strobe[n]) scnt[n]++;
      end
      check("strobe", 32'(strobe), 32'(es));
      check("active", 32'(active), 32'(ea));
   endtask

   task automatic idle();
      rst = 0; tick_en = '0; arm = '0; disarm = '0;
      cfg_we = 0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 0;
   endtask

   task automatic clr_counts();
      for (int n = 0; n < NCH; n++) scnt[n] = 0;
   endtask

   task automatic write_cfg(input int ch, input int p, input bit os);
      cfg_we = 1; cfg_ch = CHW'(ch); cfg_period = WIDTH'(p); cfg_oneshot = os;
      cycle();
      cfg_we = 0;
   endtask

   task automatic arm_ch(input int ch);
      arm[ch] = 1; cycle(); arm[ch] = 0;
   endtask

   task automatic ticks(input int ch, input int k);
      tick_en[ch] = 1;
      for (int i = 0; i < k; i++) cycle();
      tick_en[ch] = 0;
   endtask

   initial begin
      for (int n = 0; n < NCH; n++) begin
         sh_p[n] = 0; sh_o[n] = 0; cp[n] = 0; co[n] = 0;
         elapsed[n] = 0; running[n] = 0; fired[n] = 0; scnt[n] = 0;
      end
      idle();

      // Reset with every other input toggling.
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick_en = NCH'($urandom); arm = NCH'($urandom); disarm = NCH'($urandom);
         cfg_we = 1'($urandom); cfg_ch = CHW'($urandom);
         cfg_period = WIDTH'($urandom); cfg_oneshot = 1'($urandom);
         cycle();
      end
      idle();
      cycle();
      check("reset_strobe", 32'(strobe), 32'd0);
      check("reset_active", 32'(active), 32'd0);

      // Periodic, period 5 on ch0.
      write_cfg(0, 5, 0);
      arm_ch(0);
      clr_counts();
      ticks(0, 20);
      check("periodic_ch0_count", 32'(scnt[0]), 32'd4);
      check("periodic_others", 32'(scnt[1] + scnt[2] + scnt[3] + scnt[4]), 32'd0);
      disarm[0] = 1; cycle(); disarm[0] = 0;

      // Period change mid-interval on ch1: 8 then 3.
      write_cfg(1, 8, 0);
      arm_ch(1);
      clr_counts();
      ticks(1, 3);
      tick_en[1] = 1;
      write_cfg(1, 3, 0);
      ticks(1, 3);
      check("glitchfree_before_boundary", 32'(scnt[1]), 32'd0);
      ticks(1, 1);
      check("glitchfree_old_period", 32'(scnt[1]), 32'd1);
      ticks(1, 6);
      check("glitchfree_new_period", 32'(scnt[1]), 32'd3);
      disarm[1] = 1; cycle(); disarm[1] = 0;

      // One-shot, period 4 on ch2, tick_en toggling.
      write_cfg(2, 4, 1);
      arm_ch(2);
      clr_counts();
      for (int i = 0; i < 20; i++) begin
         tick_en[2] = ~i[0];
         cycle();
      end
      tick_en[2] = 0;
      check("oneshot_count", 32'(scnt[2]), 32'd1);
      check("oneshot_inactive", 32'(active[2]), 32'd0);

      // Priorities on ch3.
      write_cfg(3, 2, 0);
      arm[3] = 1; disarm[3] = 1; cycle(); arm[3] = 0; disarm[3] = 0;
      check("arm_beats_disarm", 32'(active[3]), 32'd1);
      clr_counts();
      ticks(3, 1);
      tick_en[3] = 1; arm[3] = 1; cycle(); arm[3] = 0;
      check("arm_at_terminal_no_strobe", 32'(scnt[3]), 32'd0);
      ticks(3, 1);
      check("restart_from_one", 32'(scnt[3]), 32'd0);
      ticks(3, 1);
      check("restart_strobe", 32'(scnt[3]), 32'd1);
      disarm[3] = 1; cycle(); disarm[3] = 0;

      // Period 0: armed forever, never fires.
      write_cfg(4, 0, 0);
      arm_ch(4);
      clr_counts();
      ticks(4, 100);
      check("period0_no_strobe", 32'(scnt[4]), 32'd0);
      check("period0_active", 32'(active[4]), 32'd1);

      // Out-of-range channel write must not reach ch4 (or any other).
      write_cfg(NCH, 2, 0);
      arm_ch(4);
      ticks(4, 10);
      check("bad_index_ignored", 32'(scnt[4]), 32'd0);
      disarm[4] = 1; cycle(); disarm[4] = 0;

      // Period 1: strobe every tick.
      write_cfg(0, 1, 0);
      arm_ch(0);
      clr_counts();
      ticks(0, 10);
      check("period1_every_tick", 32'(scnt[0]), 32'd10);

      // Maximum period.
      write_cfg(0, 65535, 0);
      arm_ch(0);
      clr_counts();
      ticks(0, 65534);
      check("maxperiod_not_yet", 32'(scnt[0]), 32'd0);
      ticks(0, 1);
      check("maxperiod_fires", 32'(scnt[0]), 32'd1);
      disarm[0] = 1; cycle(); disarm[0] = 0;

      // Randomized traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         tick_en = NCH'($urandom);
         for (int n = 0; n < NCH; n++) begin
            arm[n]    = ($urandom_range(0, 19) == 0);
            disarm[n] = ($urandom_range(0, 39) == 0);
         end
         cfg_we      = ($urandom_range(0, 3) == 0);
         cfg_ch      = CHW'($urandom_range(0, 7));
         cfg_period  = WIDTH'($urandom_range(0, 6));
         cfg_oneshot = 1'($urandom);
         cycle();
      end
      idle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
